// File: rtl/divider_pkg.sv
// Shared definitions for the divider result formatting stage.
package divider_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_DONE     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  // Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
  function automatic logic [BCD_DIGIT_W-1:0] dabble_fix(input logic [BCD_DIGIT_W-1:0] i_digit);
    return (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
  endfunction

endpackage

// File: rtl/divider_result_bcd_step.sv
// One double-dabble iteration for a single operand: correct digits, then shift.
module bcd_dabble_step
  import divider_pkg::*;
#(
  parameter int unsigned W = 4,
  parameter int unsigned D = 2
) (
  input  logic [4*D-1:0] i_acc,
  input  logic [W-1:0]   i_opnd,
  output logic [4*D-1:0] o_acc,
  output logic [W-1:0]   o_opnd
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * D;

  logic [BCD_W-1:0]   w_fix;
  logic [BCD_W+W-1:0] w_shift;

  // Per-digit add-3 correction, no carry between digits.
  for (genvar g = 0; g < D; g++) begin : g_digit
    assign w_fix[BCD_DIGIT_W*g +: BCD_DIGIT_W] = dabble_fix(i_acc[BCD_DIGIT_W*g +: BCD_DIGIT_W]);
  end

  // Operand MSB moves into the accumulator LSB.
  assign w_shift = {w_fix, i_opnd} << 1;
  assign o_acc   = w_shift[BCD_W+W-1:W];
  assign o_opnd  = w_shift[W-1:0];

endmodule

// File: rtl/divider_result_bcd.sv
// Converts a quotient/remainder pair to packed BCD, one bit per clock, and holds the result.
module divider_result_bcd
  import divider_pkg::*;
#(
  parameter int unsigned W = 4,
  parameter int unsigned D = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_sig,
  input  logic [W-1:0]   quotient,
  input  logic [W-1:0]   reminder,
  output logic           dong_sig,
  output logic [4*D-1:0] q_bcd,
  output logic [4*D-1:0] r_bcd,
  output logic           busy
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * D;
  localparam int unsigned CNT_W = (W > 2) ? $clog2(W) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_q_acc;
  logic [BCD_W-1:0] r_r_acc;
  logic [W-1:0]     r_q_opnd;
  logic [W-1:0]     r_r_opnd;
  logic             r_dong;
  logic             r_busy;
  logic [BCD_W-1:0] r_q_bcd;
  logic [BCD_W-1:0] r_r_bcd;

  logic [BCD_W-1:0] w_q_acc;
  logic [BCD_W-1:0] w_r_acc;
  logic [W-1:0]     w_q_opnd;
  logic [W-1:0]     w_r_opnd;

  // Quotient and remainder iterate in parallel through identical steps.
  bcd_dabble_step #(.W(W), .D(D)) u_q_step (
    .i_acc  (r_q_acc),
    .i_opnd (r_q_opnd),
    .o_acc  (w_q_acc),
    .o_opnd (w_q_opnd)
  );

  bcd_dabble_step #(.W(W), .D(D)) u_r_step (
    .i_acc  (r_r_acc),
    .i_opnd (r_r_opnd),
    .o_acc  (w_r_acc),
    .o_opnd (w_r_opnd)
  );

  // Handshake FSM, bit counter, shift registers and held result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_q_acc  <= '0;
      r_r_acc  <= '0;
      r_q_opnd <= '0;
      r_r_opnd <= '0;
      r_dong   <= 1'b0;
      r_busy   <= 1'b0;
      r_q_bcd  <= '0;
      r_r_bcd  <= '0;
    end else begin
      r_dong <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start_sig) begin
            r_q_opnd <= quotient;
            r_r_opnd <= reminder;
            r_q_acc  <= '0;
            r_r_acc  <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_q_acc  <= w_q_acc;
          r_r_acc  <= w_r_acc;
          r_q_opnd <= w_q_opnd;
          r_r_opnd <= w_r_opnd;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W - 1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Result and completion pulse become visible together.
          r_dong  <= 1'b1;
          r_q_bcd <= r_q_acc;
          r_r_bcd <= r_r_acc;
          r_busy  <= 1'b0;
          r_state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          // A request still held from the last transfer must drop before a new one.
          if (!start_sig) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dong_sig = r_dong;
  assign busy     = r_busy;
  assign q_bcd    = r_q_bcd;
  assign r_bcd    = r_r_bcd;

endmodule
